sp_ptr_gen_mod: RTL

Parametrised successor to the CPU stack-pointer register. Holds a WIDTH-bit pointer and supports:
- increment/decrement by a configurable step;
- multi-byte serial load from the BUS_WIDTH data bus, least significant byte first, with abort;
- signed relative add with half-carry/carry flag generation;
- a non-destructive "peek" add that serves pointer+offset address forms.

Sits between the data bus and the address mux; flags feed the flag register.

---
 rtl/sp_ptr_gen_mod.sv | 81 ++++++++
 1 files changed

// File: rtl/sp_ptr_gen_mod.sv
// sp_ptr_gen_mod: stack pointer with step inc/dec, serial byte load, signed relative add and peek
module sp_ptr_gen_mod #(
  parameter int WIDTH = 16,
  parameter int BUS_WIDTH = 8,
  parameter int unsigned STEP = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           sp_op,
  input  logic [BUS_WIDTH-1:0] data_bus,
  output logic [WIDTH-1:0]     sp,
  output logic [WIDTH-1:0]     rel_out,
  output logic                 h_flag,
  output logic                 c_flag,
  output logic                 load_busy,
  output logic                 load_done
);
  localparam int NBYTES = WIDTH / BUS_WIDTH;
  localparam int HB = BUS_WIDTH / 2;
  localparam int CW = $clog2(NBYTES);
  localparam int BW = (NBYTES - 1) * BUS_WIDTH;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [2:0] OP_INCR = 3'd1, OP_DECR = 3'd2, OP_LOAD = 3'd3, OP_REL = 3'd4, OP_PEEK = 3'd5;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [BW-1:0] buffer;
  logic is_load, last, is_rel;
  logic [WIDTH-1:0] ext, rel_sum;
  logic [HB:0] h_sum;
  logic [BUS_WIDTH:0] c_sum;
  always_comb begin
    is_load = sp_op == OP_LOAD;
    is_rel = sp_op == OP_REL || sp_op == OP_PEEK;
    last = state == COLLECT && count == CW'(NBYTES - 1);
    state_n = is_load && !last ? COLLECT : IDLE;
    ext = {{(WIDTH-BUS_WIDTH){data_bus[BUS_WIDTH-1]}}, data_bus};
    rel_sum = sp + ext;
    h_sum = {1'b0, sp[HB-1:0]} + {1'b0, data_bus[HB-1:0]};
    c_sum = {1'b0, sp[BUS_WIDTH-1:0]} + {1'b0, data_bus};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sp <= RESET_VALUE;
      rel_out <= '0;
      h_flag <= 1'b0;
      c_flag <= 1'b0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      count <= '0;
      buffer <= '0;
    end else begin
      state <= state_n;
      load_busy <= state_n == COLLECT;
      load_done <= is_load && last;
      if (is_load) begin
        if (last) begin
          sp <= {data_bus, buffer};
          count <= '0;
        end else begin
          for (int i = 0; i < NBYTES - 1; i++)
            if (count == CW'(i)) buffer[i*BUS_WIDTH +: BUS_WIDTH] <= data_bus;
          count <= count + 1'b1;
        end
      end else begin
        // any other op abandons a partial load and still executes
        count <= '0;
        sp <= sp_op == OP_INCR ? sp + STEP_W :
              sp_op == OP_DECR ? sp - STEP_W :
              sp_op == OP_REL  ? rel_sum : sp;
        if (is_rel) begin
          rel_out <= rel_sum;
          h_flag <= h_sum[HB];
          c_flag <= c_sum[BUS_WIDTH];
        end
      end
    end
  end
endmodule
